// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control bundle between the multicycle MIPS controller and its datapath.
// Ports (master = controller view):
//   op, zero, mem_ready            -> controller inputs (opcode, ALU zero, memory handshake)
//   iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, aluop, pcsrc, pcen, illegal_op, state -> controller outputs
interface multicycle_control_fsm_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] op;
    logic           zero;
    logic           mem_ready;
    logic           iord;
    logic           irwrite;
    logic           memwrite;
    logic           regdst;
    logic           memtoreg;
    logic           regwrite;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     aluop;
    logic [1:0]     pcsrc;
    logic           pcen;
    logic           illegal_op;
    logic [STW-1:0] state;

    modport master (
        input  op, zero, mem_ready,
        output iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, aluop, pcsrc, pcen, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, aluop, pcsrc, pcen, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control FSM sequencing fetch/decode/execute/memory/writeback for a multicycle MIPS.
// Ports: clk (rising edge), reset (async, active-high, forces FETCH),
//        bus (multicycle_control_fsm_if.master: op/zero/mem_ready in, datapath controls and debug state out).
// Optional: define MC_BNE_EN to decode bne (000101) into the BRANCH state with an inverted zero condition.
module multicycle_control_fsm #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_control_fsm_if.master bus
);
    localparam logic [STW-1:0] S_FETCH  = STW'(0);
    localparam logic [STW-1:0] S_DECODE = STW'(1);
    localparam logic [STW-1:0] S_MEMADR = STW'(2);
    localparam logic [STW-1:0] S_MEMRD  = STW'(3);
    localparam logic [STW-1:0] S_MEMWB  = STW'(4);
    localparam logic [STW-1:0] S_MEMWR  = STW'(5);
    localparam logic [STW-1:0] S_EXEC   = STW'(6);
    localparam logic [STW-1:0] S_ALUWB  = STW'(7);
    localparam logic [STW-1:0] S_BRANCH = STW'(8);
    localparam logic [STW-1:0] S_ADDIEX = STW'(9);
    localparam logic [STW-1:0] S_ADDIWB = STW'(10);
    localparam logic [STW-1:0] S_JUMP   = STW'(11);

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);

    logic [STW-1:0] state_q, state_d;
    logic           illegal;
    logic           iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]     alusrcb, aluop, pcsrc;
    logic           pcwrite, branch, branch_cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (bus.op)
                OP_LW, OP_SW: state_d = S_MEMADR;
                OP_R:         state_d = S_EXEC;
                OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
                OPW'(6'b000101): state_d = S_BRANCH;
`endif
                OP_ADDI:      state_d = S_ADDIEX;
                OP_J:         state_d = S_JUMP;
                default:      illegal = 1'b1;
            endcase
            // A stray opcode here abandons the access rather than guessing a direction
            S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : (bus.op == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH:  begin alusrcb = 2'b01; irwrite = bus.mem_ready; pcwrite = bus.mem_ready; end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
            S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
            S_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
            S_BRANCH: begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default:  ;
        endcase
    end

`ifdef MC_BNE_EN
    // Remembers which branch flavour was decoded; only meaningful in BRANCH
    logic is_bne;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     is_bne <= 1'b0;
        else if (state_q == S_DECODE)  is_bne <= (bus.op == OPW'(6'b000101));
    end
    assign branch_cond = is_bne ? ~bus.zero : bus.zero;
`else
    assign branch_cond = bus.zero;
`endif

    // Enables are masked during reset so mem_ready cannot leak a write through FETCH
    assign bus.iord       = iord;
    assign bus.irwrite    = irwrite & ~reset;
    assign bus.memwrite   = memwrite & ~reset;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite & ~reset;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.aluop      = aluop;
    assign bus.pcsrc      = pcsrc;
    assign bus.pcen       = (pcwrite | (branch & branch_cond)) & ~reset;
    assign bus.illegal_op = illegal & ~reset;
    assign bus.state      = state_q;
endmodule
